// File: rtl/serpent_round_engine.sv
// Iterative Serpent-128 encryption datapath: one round per clock over a
// bitsliced 4x32-bit state, subkeys fetched from the key schedule by index.
module serpent_round_engine #(
  parameter int unsigned NUM_ROUNDS = 32,
  parameter int unsigned SK_IDX_W   = 6
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [127:0]        i_pt,
  output logic [SK_IDX_W-1:0] o_sk_idx,
  input  logic [127:0]        i_subkey,
  input  logic                i_subkey_ready,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [127:0]        o_ct
);

  localparam logic [SK_IDX_W-1:0] LastRound = SK_IDX_W'(NUM_ROUNDS - 1);
  localparam logic [SK_IDX_W-1:0] FinalIdx  = SK_IDX_W'(NUM_ROUNDS);

  // Nibble n of each entry holds S(n).
  localparam logic [63:0] SBOX_TAB [8] = '{
    64'hc907_24de_b56a_1f83,
    64'h43d6_8eb1_a509_72cf,
    64'h25b0_4e1d_fac3_9768,
    64'he57a_421d_369c_8bf0,
    64'hd7e9_a452_6b0c_38f1,
    64'h176d_8e30_c9a4_b25f,
    64'h0a3d_f19e_b648_5c27,
    64'h6539_ac47_b28e_0fd1
  };

  typedef enum logic [1:0] {StIdle, StRound, StFinal, StOut} state_e;

  state_e               state_q, state_d;
  logic [SK_IDX_W-1:0]  rnd_q, rnd_d;
  logic [3:0][31:0]     x_q, x_d;
  logic [127:0]         ct_q, ct_d;
  logic                 vld_q, vld_d;
  logic [3:0][31:0]     kx, keyed, subbed;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Bitsliced S-box: bit j of X3..X0 forms one nibble.
  function automatic logic [3:0][31:0] sbox_layer(input logic [3:0][31:0] x,
                                                  input logic [2:0] sel);
    logic [3:0][31:0] y;
    logic [63:0]      tab;
    logic [3:0]       nib;
    logic [3:0]       s;
    tab = SBOX_TAB[sel];
    y   = '0;
    for (int j = 0; j < 32; j++) begin
      nib     = {x[3][j], x[2][j], x[1][j], x[0][j]};
      s       = tab[{nib, 2'b00} +: 4];
      y[0][j] = s[0];
      y[1][j] = s[1];
      y[2][j] = s[2];
      y[3][j] = s[3];
    end
    return y;
  endfunction

  function automatic logic [3:0][31:0] lin_xform(input logic [3:0][31:0] x);
    logic [31:0] x0, x1, x2, x3;
    x0 = rotl(x[0], 13);
    x2 = rotl(x[2], 3);
    x1 = x[1] ^ x0 ^ x2;
    x3 = x[3] ^ x2 ^ (x0 << 3);
    x1 = rotl(x1, 1);
    x3 = rotl(x3, 7);
    x0 = x0 ^ x1 ^ x3;
    x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = rotl(x0, 5);
    x2 = rotl(x2, 22);
    return {x3, x2, x1, x0};
  endfunction

  // Subkey words arrive MSW-first (K0 in [127:96]); state words are LSW-first.
  assign kx = {i_subkey[31:0], i_subkey[63:32], i_subkey[95:64], i_subkey[127:96]};

  // Next-state: accept, per-round update with stall, final whitening, output hold.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    x_d     = x_q;
    ct_d    = ct_q;
    vld_d   = vld_q;
    keyed   = x_q ^ kx;
    subbed  = sbox_layer(keyed, rnd_q[2:0]);
    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          x_d     = i_pt;
          rnd_d   = '0;
          state_d = StRound;
        end
      end
      StRound: begin
        if (i_subkey_ready) begin
          if (rnd_q == LastRound) begin
            x_d     = subbed;
            state_d = StFinal;
          end else begin
            x_d   = lin_xform(subbed);
            rnd_d = rnd_q + 1'b1;
          end
        end
      end
      StFinal: begin
        if (i_subkey_ready) begin
          x_d     = keyed;
          ct_d    = keyed;
          state_d = StOut;
        end
      end
      StOut: begin
        // Ciphertext register settles first; valid is presented one cycle later.
        if (!vld_q) begin
          vld_d = 1'b1;
        end else if (i_ready) begin
          vld_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous abort.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      rnd_q   <= '0;
      x_q     <= '0;
      ct_q    <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      x_q     <= x_d;
      ct_q    <= ct_d;
      vld_q   <= vld_d;
    end
  end

  // Subkey index decoded from registered state only, so it cannot glitch.
  always_comb begin
    o_sk_idx = '0;
    if (state_q == StRound) begin
      o_sk_idx = rnd_q;
    end else if (state_q == StFinal) begin
      o_sk_idx = FinalIdx;
    end
  end

  assign o_ready = (state_q == StIdle);
  assign o_valid = vld_q;
  assign o_ct    = ct_q;

endmodule

// File: doc/serpent_round_engine.md
Name: serpent_round_engine

Overview:
Iterative Serpent-128 encryption datapath, placed directly downstream of Serpent_Key_Schedule.
- Computes one round per clock over a 128-bit bitsliced state.
- Drives a subkey index to the key schedule's subkey array mux and consumes the selected 128-bit subkey.
- Valid/ready handshakes on the plaintext input and the ciphertext output.

Parameters:
NUM_ROUNDS, 32, number of S-box/linear-transform rounds; the final key XOR uses subkey NUM_ROUNDS.
SK_IDX_W, 6, width of the subkey index bus; must hold NUM_ROUNDS.

Ports:
i_clk  in  1  the one clock
i_rst  in  1  reset, asynchronous, active-high
i_valid  in  1  plaintext valid
o_ready  out  1  engine can accept a block
i_pt  in  128  plaintext; X0=i_pt[31:0], X1=[63:32], X2=[95:64], X3=[127:96]
o_sk_idx  out  SK_IDX_W  subkey index requested this cycle
i_subkey  in  128  subkeys[o_sk_idx], combinational from the key schedule; K0=[127:96], K1=[95:64], K2=[63:32], K3=[31:0]
i_subkey_ready  in  1  key schedule output stable
o_valid  out  1  ciphertext valid
i_ready  in  1  downstream accepts ciphertext
o_ct  out  128  ciphertext, same word packing as i_pt

Behaviour:
- One clock and one reset only. i_rst is asynchronous and active-high.
- Reset values:
  - State: IDLE.
  - o_ready=1, o_valid=0, o_ct=0, o_sk_idx=0.
  - Round counter 0, state words 0.
- FSM states: IDLE, ROUND, FINAL, OUT.
- IDLE:
  - o_ready=1.
  - On i_valid & o_ready: latch i_pt into X0..X3, clear counter r, go to ROUND.
- ROUND:
  - o_ready=0, o_sk_idx=r.
  - If i_subkey_ready=0: hold all state (stall); no round is consumed.
  - Otherwise, per edge:
    - Xi ^= Ki.
    - Apply S-box S(r mod 8) bitsliced: for each j in 0..31, nibble {X3[j],X2[j],X1[j],X0[j]} is replaced by S(nibble), returned in the same bit order.
    - If r<NUM_ROUNDS-1, apply the linear transform, then r++.
    - If r=NUM_ROUNDS-1, skip the linear transform and go to FINAL.
- S-boxes: the standard Serpent tables S0..S7, e.g. S0 = 3,8,15,1,10,6,5,11,14,13,4,2,7,0,9,12.
- Linear transform (<<< is rotate-left, << is shift-left, logical):
  - X0<<<=13
  - X2<<<=3
  - X1^=X0^X2
  - X3^=X2^(X0<<3)
  - X1<<<=1
  - X3<<<=7
  - X0^=X1^X3
  - X2^=X3^(X1<<7)
  - X0<<<=5
  - X2<<<=22
- FINAL:
  - o_sk_idx=NUM_ROUNDS.
  - Stalls on i_subkey_ready=0.
  - Otherwise Xi ^= Ki, register o_ct, go to OUT.
- OUT:
  - o_valid=1; o_ct is held stable while i_ready=0.
  - On i_ready: o_valid drops and the FSM returns to IDLE; o_ready rises the following cycle.
  - No overlap: a new block is accepted only after the output handshake.
- Latency:
  - Handshake edge T, no stalls: rounds on edges T+1..T+32, final XOR on T+33.
  - o_valid high after edge T+34, i.e. 34 cycles of latency.
  - Each cycle with i_subkey_ready low adds one cycle.
- o_sk_idx is registered-state driven and never glitches mid-cycle. During IDLE/OUT it is 0.
- i_valid while busy is ignored; upstream holds i_pt until o_ready.
- Reset mid-operation: immediate abort to reset values; the partial block is discarded and no o_valid is produced.
- i_subkey_ready dropping mid-block (key change): stall. The block completes with whatever subkeys are present when ready reasserts; the engine does not restart.
- All arithmetic is XOR/rotate on 32-bit words; there are no carries.

Test Plan:
- Reset: assert i_rst mid-cycle asynchronously -> o_ready=1, o_valid=0, o_ct=0 immediately, without waiting for a clock edge.
- Nominal:
  - Stimulus: key 0x00..00 through Serpent_Key_Schedule, i_pt=0, i_ready=1.
  - Expected: o_sk_idx steps 0..32 once each; o_valid at exactly 34 cycles after acceptance; o_ct equals the bench model.
  - Repeat with i_pt=0xFFFF...FF and random keys; 1000 blocks match the model.
- Stall: drop i_subkey_ready for 5 cycles during round 10 -> o_sk_idx stays 10, state is unchanged, latency is 39 cycles, o_ct is unchanged vs the unstalled run.
- Backpressure: hold i_ready=0 for 20 cycles after o_valid -> o_ct stable, o_ready stays 0, and i_valid pulses in that window are ignored.
- Back-to-back: i_valid held high with two blocks -> the second is accepted one cycle after the first output handshake; both results are correct.
- Reset mid-block: assert i_rst at round 17, release, submit a new block -> no spurious o_valid, and the new result is correct.
